// File: rtl/ex_alu_mdu.sv
// Registered integer execute stage: single-cycle ALU plus an iterative
// shift-add multiplier and restoring divider, with valid/ready on both sides.
module ex_alu_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic            b_imm,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      rd_out,
    output logic            out_we,
    output logic [XLEN-1:0] rd_data,
    output logic            busy
);

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    typedef enum logic {IDLE, CALC} state_t;
    state_t state, state_next;

    logic [SHW-1:0]  count;
    logic [XLEN-1:0] acc_hi, acc_lo, opnd;
    logic            is_div_q, neg_q, neg_r;
    logic [1:0]      sel_q;
    logic [4:0]      rd_q;

    logic accept, load_iter, write_single, calc_done;

    // Operand selection and op-class decode
    logic [XLEN-1:0] opa, opb, a_mag, b_mag;
    logic [SHW-1:0]  shamt;
    logic            is_mdu, is_div, div_zero, div_ovf, is_iter;
    logic            a_signed, b_signed, a_neg, b_neg;

    assign opa      = rs1_data;
    assign opb      = b_imm ? imm : rs2_data;
    assign shamt    = opb[SHW-1:0];
    assign is_mdu   = (op[4:3] == 2'b10);
    assign is_div   = is_mdu && op[2];
    assign div_zero = (opb == '0);
    assign div_ovf  = !op[0] && (opa == MIN_NEG) && (opb == ALL_ONES);
    assign is_iter  = is_mdu && !(is_div && (div_zero || div_ovf));
    assign a_signed = is_mdu && (op[2] ? !op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10));
    assign b_signed = is_mdu && (op[2] ? !op[0] : (op[1:0] == 2'b01));
    assign a_neg    = a_signed && opa[XLEN-1];
    assign b_neg    = b_signed && opb[XLEN-1];
    assign a_mag    = a_neg ? -opa : opa;
    assign b_mag    = b_neg ? -opb : opb;

    // Single-cycle results, including the divide special cases that skip iteration
    logic [XLEN-1:0] alu_result;
    logic            alu_defined;
    always_comb begin
        alu_result  = '0;
        alu_defined = 1'b1;
        case (op)
            5'd0:  alu_result = opa + opb;
            5'd1:  alu_result = opa - opb;
            5'd2:  alu_result = opa & opb;
            5'd3:  alu_result = opa | opb;
            5'd4:  alu_result = opa ^ opb;
            5'd5:  alu_result = opa << shamt;
            5'd6:  alu_result = opa >> shamt;
            5'd7:  alu_result = $signed(opa) >>> shamt;
            5'd8:  alu_result = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
            5'd9:  alu_result = {{(XLEN-1){1'b0}}, (opa < opb)};
            5'd10: alu_result = opb;
            5'd16, 5'd17, 5'd18, 5'd19: alu_result = '0;
            5'd20, 5'd21: alu_result = div_zero ? ALL_ONES : MIN_NEG;
            5'd22, 5'd23: alu_result = div_zero ? opa : '0;
            default: alu_defined = 1'b0;
        endcase
    end

    // One multiply or divide iteration step and the sign-corrected final result
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   hi_next, lo_next, quot, remd, mdu_result;
    logic [2*XLEN-1:0] product, product_fix;
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ge    = !div_diff[XLEN];
    always_comb begin
        if (is_div_q) begin
            hi_next = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_next = {acc_lo[XLEN-2:0], div_ge};
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
        product     = {hi_next, lo_next};
        product_fix = neg_q ? -product : product;
        quot        = neg_q ? -lo_next : lo_next;
        remd        = neg_r ? -hi_next : hi_next;
        if (is_div_q)
            mdu_result = sel_q[1] ? remd : quot;
        else
            mdu_result = (sel_q == 2'b00) ? product_fix[XLEN-1:0] : product_fix[2*XLEN-1:XLEN];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst || flush)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (load_iter) state_next = CALC;
            CALC: if (count == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and control outputs
    always_comb begin
        in_ready     = !rst && !flush && (state == IDLE) && (!out_valid || out_ready);
        busy         = (state == CALC);
        accept       = in_valid && in_ready;
        load_iter    = accept && is_iter;
        write_single = accept && !is_iter;
        calc_done    = (state == CALC) && (count == '0) && !flush;
    end

    // Iteration registers: latch magnitudes on accept, step once per CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            sel_q    <= '0;
            rd_q     <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (load_iter) begin
            count    <= SHW'(XLEN-1);
            acc_hi   <= '0;
            acc_lo   <= is_div ? a_mag : b_mag;
            opnd     <= is_div ? b_mag : a_mag;
            is_div_q <= is_div;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            sel_q    <= op[1:0];
            rd_q     <= rd;
        end else if (state == CALC) begin
            acc_hi <= hi_next;
            acc_lo <= lo_next;
            count  <= count - 1'b1;
        end
    end

    // Output register: holds a result until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            rd_out    <= '0;
            out_we    <= 1'b0;
            rd_data   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (calc_done) begin
            out_valid <= 1'b1;
            rd_out    <= rd_q;
            out_we    <= (rd_q != 5'd0);
            rd_data   <= mdu_result;
        end else if (write_single) begin
            out_valid <= 1'b1;
            rd_out    <= rd;
            out_we    <= alu_defined && (rd != 5'd0);
            rd_data   <= alu_result;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_alu_mdu.sv
// Directed and random checks of ex_alu_mdu against a behavioural reference model.
module tb_ex_alu_mdu;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, b_imm, out_valid, out_ready, out_we, busy;
    logic [4:0]  op, rd, rd_out;
    logic [31:0] rs1_data, rs2_data, imm, rd_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        int          acc;
    } exp_t;
    exp_t sb[$];

    ex_alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .b_imm(b_imm), .rd(rd), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .rd_out(rd_out),
        .out_we(out_we), .rd_data(rd_data), .busy(busy)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model of every op, written directly from the arithmetic definitions
    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        case (o)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return a << b[4:0];
            5'd6:  return a >> b[4:0];
            5'd7:  return $signed(a) >>> b[4:0];
            5'd8:  return {31'b0, ($signed(a) < $signed(b))};
            5'd9:  return {31'b0, (a < b)};
            5'd10: return b;
            5'd16: return a * b;
            5'd17: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[63:32]; end
            5'd18: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return ps[63:32]; end
            5'd19: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            5'd20: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            5'd23: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one op (called at a negedge), push its expectation, return at the next negedge
    task automatic apply_stimulus(input logic [4:0] o, input logic [4:0] r, input logic [31:0] a,
                                  input logic [31:0] b, input logic bi, input logic [31:0] im,
                                  input logic [31:0] exp_data, output int waited);
        int   n = 0;
        exp_t e;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        waited = n;
        if (!in_ready) begin
            check_output("accept_timeout", {31'b0, in_ready}, 32'd1);
            return;
        end
        op = o; rd = r; rs1_data = a; rs2_data = b; b_imm = bi; imm = im; in_valid = 1'b1;
        e.rd   = r;
        e.we   = ((o <= 5'd10) || (o >= 5'd16 && o <= 5'd23)) && (r != 5'd0);
        e.data = exp_data;
        e.acc  = cyc;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for the next result and compare it with the scoreboard head
    task automatic wait_result(input string tag, input int exp_lat, input int exp_busy);
        int   n = 0;
        int   bc = 0;
        exp_t e;
        while (!out_valid && n < 100) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check_output({tag, "_timeout"}, {31'b0, out_valid}, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            check_output({tag, "_unexpected"}, {31'b0, out_valid}, 32'd0);
            return;
        end
        e = sb.pop_front();
        check_output({tag, "_data"}, rd_data, e.data);
        check_output({tag, "_rd"}, {27'b0, rd_out}, {27'b0, e.rd});
        check_output({tag, "_we"}, {31'b0, out_we}, {31'b0, e.we});
        if (exp_lat > 0) check_output({tag, "_lat"}, 32'(cyc - e.acc), 32'(exp_lat));
        if (exp_busy >= 0) check_output({tag, "_busy"}, 32'(bc), 32'(exp_busy));
        @(negedge clk);
    endtask

    // Directed sequence
    initial begin
        int w, cnt;
        logic [4:0]  ro;
        logic [31:0] ra, rb;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; b_imm = 1'b0;
        op = '0; rd = '0; rs1_data = '0; rs2_data = '0; imm = '0;
        repeat (3) @(negedge clk);
        check_output("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check_output("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("rst_out_we", {31'b0, out_we}, 32'd0);
        check_output("rst_rd_out", {27'b0, rd_out}, 32'd0);
        check_output("rst_rd_data", rd_data, 32'd0);
        check_output("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);

        // Single-cycle ALU ops
        apply_stimulus(5'd0, 5'd5, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'h0, w); wait_result("add_wrap", 1, 0);
        apply_stimulus(5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'h0, w); wait_result("add_rd0", 1, 0);
        apply_stimulus(5'd7, 5'd3, 32'h8000_0000, 32'h24, 1'b0, 32'd0, 32'hF800_0000, w); wait_result("sra", 1, 0);
        apply_stimulus(5'd9, 5'd4, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd1, w); wait_result("sltiu", 1, 0);
        apply_stimulus(5'd8, 5'd6, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd1, w); wait_result("slt", 1, 0);
        apply_stimulus(5'd1, 5'd7, 32'd3, 32'd5, 1'b0, 32'd0, 32'hFFFF_FFFE, w); wait_result("sub", 1, 0);
        apply_stimulus(5'd5, 5'd8, 32'd1, 32'h3F, 1'b0, 32'd0, 32'h8000_0000, w); wait_result("sll", 1, 0);
        apply_stimulus(5'd6, 5'd8, 32'h8000_0000, 32'd31, 1'b0, 32'd0, 32'd1, w); wait_result("srl", 1, 0);
        apply_stimulus(5'd4, 5'd9, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 32'd0, 32'hFF00_EDCB, w); wait_result("xor", 1, 0);
        apply_stimulus(5'd10, 5'd9, 32'd77, 32'd0, 1'b1, 32'h1234_5000, 32'h1234_5000, w); wait_result("lui", 1, 0);
        apply_stimulus(5'd11, 5'd9, 32'd77, 32'd3, 1'b0, 32'd0, 32'h0, w); wait_result("undef", 1, 0);

        // Multiply
        apply_stimulus(5'd17, 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h0, w); wait_result("mulh", 33, 32);
        apply_stimulus(5'd19, 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'hFFFF_FFFE, w); wait_result("mulhu", 33, 32);
        apply_stimulus(5'd16, 5'd11, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'd0, 32'hFFFF_FFEB, w); wait_result("mul", 33, 32);
        apply_stimulus(5'd18, 5'd11, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0, 32'hFFFF_FFFF, w); wait_result("mulhsu", 33, 32);

        // Divide, including the bypassed special cases
        apply_stimulus(5'd20, 5'd12, 32'd7, 32'd0, 1'b0, 32'd0, 32'hFFFF_FFFF, w); wait_result("div_by0", 1, 0);
        apply_stimulus(5'd22, 5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h0, w); wait_result("rem_ovf", 1, 0);
        apply_stimulus(5'd20, 5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, w); wait_result("div_ovf", 1, 0);
        apply_stimulus(5'd23, 5'd12, 32'd9, 32'd0, 1'b0, 32'd0, 32'd9, w); wait_result("remu_by0", 1, 0);
        apply_stimulus(5'd20, 5'd13, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 32'hFFFF_FFFD, w); wait_result("div_neg", 33, 32);
        apply_stimulus(5'd22, 5'd13, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 32'hFFFF_FFFF, w); wait_result("rem_neg", 33, 32);
        apply_stimulus(5'd21, 5'd14, 32'd100, 32'd7, 1'b0, 32'd0, 32'd14, w); wait_result("divu", 33, 32);
        apply_stimulus(5'd23, 5'd14, 32'd100, 32'd7, 1'b0, 32'd0, 32'd2, w); wait_result("remu", 33, 32);

        // Random ops checked against the model
        for (int i = 0; i < 8; i++) begin
            int idx;
            idx = $urandom_range(0, 18);
            ro  = (idx <= 10) ? 5'(idx) : 5'(idx + 5);
            ra  = $urandom();
            rb  = (i == 3) ? 32'd0 : $urandom();
            apply_stimulus(ro, 5'd15, ra, rb, 1'b0, 32'd0, model(ro, ra, rb), w);
            wait_result("random", 0, -1);
        end

        // Backpressure: result held, no accept, then same-cycle handoff
        out_ready = 1'b0;
        apply_stimulus(5'd0, 5'd11, 32'd10, 32'd20, 1'b0, 32'd0, 32'd30, w);
        wait_result("bp_first", 1, 0);
        for (int i = 0; i < 5; i++) begin
            check_output("bp_hold_data", rd_data, 32'd30);
            check_output("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check_output("bp_out_valid", {31'b0, out_valid}, 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        apply_stimulus(5'd0, 5'd12, 32'd1, 32'd2, 1'b0, 32'd0, 32'd3, w);
        check_output("bp_same_cycle", 32'(w), 32'd0);
        wait_result("bp_next", 1, 0);

        // Flush on the tenth busy cycle of a DIVU
        apply_stimulus(5'd21, 5'd10, 32'd1000, 32'd7, 1'b0, 32'd0, 32'd142, w);
        repeat (9) @(negedge clk);
        check_output("flush_busy_before", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        op = 5'd0; rd = 5'd1; rs1_data = 32'd1; rs2_data = 32'd1; in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check_output("flush_busy", {31'b0, busy}, 32'd0);
        check_output("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("flush_in_ready", {31'b0, in_ready}, 32'd1);
        void'(sb.pop_back());
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) cnt++;
            @(negedge clk);
        end
        check_output("flush_no_result", 32'(cnt), 32'd0);
        apply_stimulus(5'd0, 5'd6, 32'd40, 32'd2, 1'b0, 32'd0, 32'd42, w); wait_result("flush_after", 1, 0);

        // Reset in the middle of a multiply
        apply_stimulus(5'd19, 5'd7, 32'd5, 32'd6, 1'b0, 32'd0, 32'd0, w);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_mid_busy", {31'b0, busy}, 32'd0);
        check_output("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("rst_mid_in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        void'(sb.pop_back());
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) cnt++;
            @(negedge clk);
        end
        check_output("rst_mid_no_result", 32'(cnt), 32'd0);
        apply_stimulus(5'd2, 5'd8, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 32'd0, 32'h0F00_0F00, w); wait_result("and_after_rst", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
